// File: rtl/addsub_flags_pipe.sv
// Two-stage N-bit add/sub unit with NZCV flags, carry-chained ops and a committed flag register.
// Latency 2 cycles, 1 op/cycle; a stalled output holds both stages and drops in_ready once S1 is full.
module addsub_flags_pipe #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [2:0]   in_op,
  input  logic         in_setf,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_q,
  output logic         out_z,
  output logic         out_n,
  output logic         out_c,
  output logic         out_v,
  output logic         out_err,
  output logic [3:0]   flags
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADC = 3'b010;
  localparam logic [2:0] OP_SBC = 3'b011;
  localparam logic [2:0] OP_CMP = 3'b100;
  localparam logic [2:0] OP_NEG = 3'b101;

  logic         s1_valid;
  logic [N-1:0] s1_a;
  logic [N-1:0] s1_b;
  logic [2:0]   s1_op;
  logic         s1_setf;
  logic         out_setf;

  logic         adv;
  logic         cin;
  logic [N-1:0] op_x;
  logic [N-1:0] op_y;
  logic         op_ci;
  logic [N:0]   ext;
  logic [N-1:0] res_q;
  logic         res_v;
  logic         res_err;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv || !s1_valid;

  // An older setf op still at the output retires on the same edge S2 advances,
  // so its carry is the architectural carry this op must see.
  assign cin = (out_valid && out_setf && !out_err) ? out_c : flags[1];

  always_comb begin
    op_x  = s1_a;
    op_y  = s1_b;
    op_ci = 1'b0;
    case (s1_op)
      OP_ADD: ;
      OP_SUB, OP_CMP: begin
        op_y  = ~s1_b;
        op_ci = 1'b1;
      end
      OP_ADC: op_ci = cin;
      OP_SBC: begin
        op_y  = ~s1_b;
        op_ci = cin;
      end
      OP_NEG: begin
        op_x  = '0;
        op_y  = ~s1_a;
        op_ci = 1'b1;
      end
      default: ;
    endcase
    ext = {1'b0, op_x} + {1'b0, op_y} + {{N{1'b0}}, op_ci};
  end

  assign res_q   = ext[N-1:0];
  assign res_v   = (op_x[N-1] == op_y[N-1]) && (res_q[N-1] != op_x[N-1]);
  assign res_err = s1_op[2] && s1_op[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_op     <= '0;
      s1_setf   <= 1'b0;
      out_valid <= 1'b0;
      out_q     <= '0;
      out_z     <= 1'b0;
      out_n     <= 1'b0;
      out_c     <= 1'b0;
      out_v     <= 1'b0;
      out_err   <= 1'b0;
      out_setf  <= 1'b0;
      flags     <= 4'b0000;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_a    <= in_a;
          s1_b    <= in_b;
          s1_op   <= in_op;
          s1_setf <= in_setf;
        end
      end
      if (adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_q    <= res_q;
          out_z    <= (res_q == '0);
          out_n    <= res_q[N-1];
          out_c    <= ext[N];
          out_v    <= res_v;
          out_err  <= res_err;
          out_setf <= s1_setf;
        end
      end
      if (out_valid && out_ready && out_setf && !out_err) begin
        flags <= {out_n, out_z, out_c, out_v};
      end
    end
  end

endmodule
